// File: rtl/atm_keypad_entry.sv
// Keypad credential entry for the ATM: collects a 3-digit BCD account
// number and a 1-digit PIN, hands them to the authenticator, tracks failed
// attempts with a timed lockout, and ends the session on cancel or idle timeout.
module atm_keypad_entry #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keyValid,
  input  logic [3:0]  keyCode,
  input  logic        isAuthenticated,
  output logic [11:0] accNumber,
  output logic [3:0]  pin,
  output logic        credValid,
  output logic        exit,
  output logic        locked,
  output logic        keyError,
  output logic        authFail,
  output logic [2:0]  attempts
);

  localparam int TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LockW  = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerReload = TimerW'(TIMEOUT_CYCLES);
  localparam logic [LockW-1:0]  LockReload  = LockW'(LOCKOUT_CYCLES);
  localparam logic [2:0]        MaxAttempts = 3'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    ACC_ENTRY,
    PIN_ENTRY,
    CHECK,
    SESSION,
    LOCKED
  } stateT;

  stateT             state, stateNext;
  logic [11:0]       accNumberNext;
  logic [1:0]        accCount, accCountNext;
  logic [3:0]        pinNext;
  logic              pinSet, pinSetNext;
  logic [1:0]        checkCnt, checkCntNext;
  logic              authReg, authRegNext;
  logic [2:0]        attemptsNext, attemptsInc;
  logic [LockW-1:0]  lockCnt, lockCntNext;
  logic [TimerW-1:0] timer, timerNext;
  logic              credValidNext, exitNext, lockedNext, keyErrorNext, authFailNext;
  logic              doCancel;

  logic isDigit, isClear, isEnter, isCancel, isInvalid;
  logic timerActive, timerExpire;

  // Key decode and inactivity-timer status; a key in the expiry cycle suppresses expiry
  assign isDigit     = (keyCode <= 4'd9);
  assign isClear     = (keyCode == 4'hA);
  assign isEnter     = (keyCode == 4'hB);
  assign isCancel    = (keyCode == 4'hC);
  assign isInvalid   = (keyCode >= 4'hD);
  assign attemptsInc = attempts + 3'd1;
  assign timerActive = (state == PIN_ENTRY) || (state == CHECK) || (state == SESSION) ||
                       ((state == ACC_ENTRY) && (accCount != 2'd0));
  assign timerExpire = timerActive && !keyValid && (timer == TimerW'(1));

  // State register plus every registered output and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC_ENTRY;
      accNumber <= '0;
      accCount  <= '0;
      pin       <= '0;
      pinSet    <= 1'b0;
      checkCnt  <= '0;
      authReg   <= 1'b0;
      attempts  <= '0;
      lockCnt   <= '0;
      timer     <= TimerReload;
      credValid <= 1'b0;
      exit      <= 1'b0;
      locked    <= 1'b0;
      keyError  <= 1'b0;
      authFail  <= 1'b0;
    end else begin
      state     <= stateNext;
      accNumber <= accNumberNext;
      accCount  <= accCountNext;
      pin       <= pinNext;
      pinSet    <= pinSetNext;
      checkCnt  <= checkCntNext;
      authReg   <= authRegNext;
      attempts  <= attemptsNext;
      lockCnt   <= lockCntNext;
      timer     <= timerNext;
      credValid <= credValidNext;
      exit      <= exitNext;
      locked    <= lockedNext;
      keyError  <= keyErrorNext;
      authFail  <= authFailNext;
    end
  end

  // Next-state and next-output logic; cancel/timeout is applied last so it wins
  always_comb begin
    stateNext     = state;
    accNumberNext = accNumber;
    accCountNext  = accCount;
    pinNext       = pin;
    pinSetNext    = pinSet;
    checkCntNext  = checkCnt;
    authRegNext   = authReg;
    attemptsNext  = attempts;
    lockCntNext   = lockCnt;
    timerNext     = timer;
    keyErrorNext  = 1'b0;
    exitNext      = 1'b0;
    authFailNext  = 1'b0;
    doCancel      = timerExpire || (keyValid && isCancel && (state != LOCKED));

    case (state)
      ACC_ENTRY: begin
        if (keyValid) begin
          if (isDigit) begin
            if (accCount != 2'd3) begin
              accNumberNext = {accNumber[7:0], keyCode};
              accCountNext  = accCount + 2'd1;
            end else begin
              keyErrorNext = 1'b1;
            end
          end else if (isClear) begin
            accNumberNext = '0;
            accCountNext  = '0;
          end else if (isEnter) begin
            if (accCount == 2'd3) stateNext = PIN_ENTRY;
            else keyErrorNext = 1'b1;
          end else if (isInvalid) begin
            keyErrorNext = 1'b1;
          end
        end
      end

      PIN_ENTRY: begin
        if (keyValid) begin
          if (isDigit) begin
            if (!pinSet) begin
              pinNext    = keyCode;
              pinSetNext = 1'b1;
            end else begin
              keyErrorNext = 1'b1;
            end
          end else if (isClear) begin
            pinNext    = '0;
            pinSetNext = 1'b0;
          end else if (isEnter) begin
            if (pinSet) begin
              stateNext    = CHECK;
              checkCntNext = 2'd0;
            end else begin
              keyErrorNext = 1'b1;
            end
          end else if (isInvalid) begin
            keyErrorNext = 1'b1;
          end
        end
      end

      CHECK: begin
        case (checkCnt)
          2'd0: checkCntNext = 2'd1;
          2'd1: begin
            authRegNext  = isAuthenticated;
            checkCntNext = 2'd2;
          end
          default: begin
            checkCntNext = 2'd0;
            if (authReg) begin
              stateNext    = SESSION;
              attemptsNext = '0;
            end else begin
              authFailNext = 1'b1;
              attemptsNext = attemptsInc;
              if (attemptsInc >= MaxAttempts) begin
                stateNext   = LOCKED;
                lockCntNext = LockReload;
              end else begin
                stateNext  = PIN_ENTRY;
                pinNext    = '0;
                pinSetNext = 1'b0;
              end
            end
          end
        endcase
      end

      SESSION: begin
      end

      LOCKED: begin
        if (lockCnt <= LockW'(1)) begin
          stateNext     = ACC_ENTRY;
          attemptsNext  = '0;
          lockCntNext   = '0;
          accNumberNext = '0;
          accCountNext  = '0;
          pinNext       = '0;
          pinSetNext    = 1'b0;
        end else begin
          lockCntNext = lockCnt - LockW'(1);
        end
      end

      default: stateNext = ACC_ENTRY;
    endcase

    if (doCancel) begin
      stateNext     = ACC_ENTRY;
      accNumberNext = '0;
      accCountNext  = '0;
      pinNext       = '0;
      pinSetNext    = 1'b0;
      checkCntNext  = 2'd0;
      attemptsNext  = attempts;
      authFailNext  = 1'b0;
      keyErrorNext  = 1'b0;
      exitNext      = 1'b1;
    end

    if (doCancel || keyValid || (stateNext != state) || !timerActive) timerNext = TimerReload;
    else timerNext = timer - TimerW'(1);

    credValidNext = (stateNext == SESSION) || ((stateNext == CHECK) && (state == CHECK));
    lockedNext    = (stateNext == LOCKED);
  end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed self-checking bench for atm_keypad_entry with short timeout/lockout.
module tb_atm_keypad_entry;

  logic        clk;
  logic        rst;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic        isAuthenticated;
  logic [11:0] accNumber;
  logic [3:0]  pin;
  logic        credValid;
  logic        exitPulse;
  logic        locked;
  logic        keyError;
  logic        authFail;
  logic [2:0]  attempts;

  int assertCount = 0;
  int failCount   = 0;

  atm_keypad_entry #(
    .MAX_ATTEMPTS(3),
    .LOCKOUT_CYCLES(20),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keyValid(keyValid),
    .keyCode(keyCode),
    .isAuthenticated(isAuthenticated),
    .accNumber(accNumber),
    .pin(pin),
    .credValid(credValid),
    .exit(exitPulse),
    .locked(locked),
    .keyError(keyError),
    .authFail(authFail),
    .attempts(attempts)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one key for one cycle starting at a falling edge; returns at the
  // falling edge after the rising edge that sampled it
  task automatic applyStimulus(input logic [3:0] code);
    keyValid = 1'b1;
    keyCode  = code;
    @(negedge clk);
    keyValid = 1'b0;
    keyCode  = 4'h0;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    keyValid = 1'b0;
    keyCode = 4'h0;
    isAuthenticated = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset accNumber", accNumber, 12'h000);
    checkOutput("reset pin", {8'h0, pin}, 12'h0);
    checkOutput("reset credValid", {11'h0, credValid}, 12'h0);
    checkOutput("reset exit", {11'h0, exitPulse}, 12'h0);
    checkOutput("reset locked", {11'h0, locked}, 12'h0);
    checkOutput("reset attempts", {9'h0, attempts}, 12'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] Login");
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    checkOutput("login accNumber", accNumber, 12'h123);
    applyStimulus(4'hB);
    applyStimulus(4'd7);
    checkOutput("login pin", {8'h0, pin}, 12'h007);
    checkOutput("login no keyError", {11'h0, keyError}, 12'h0);
    isAuthenticated = 1'b1;
    applyStimulus(4'hB);
    checkOutput("credValid N", {11'h0, credValid}, 12'h0);
    @(negedge clk);
    checkOutput("credValid N+1", {11'h0, credValid}, 12'h1);
    @(negedge clk);
    checkOutput("credValid N+2", {11'h0, credValid}, 12'h1);
    @(negedge clk);
    checkOutput("session credValid", {11'h0, credValid}, 12'h1);
    checkOutput("session authFail", {11'h0, authFail}, 12'h0);
    checkOutput("session attempts", {9'h0, attempts}, 12'h0);
    isAuthenticated = 1'b0;
    applyStimulus(4'd5);
    checkOutput("session digit ignored", {8'h0, pin}, 12'h007);
    checkOutput("session no keyError", {11'h0, keyError}, 12'h0);
    applyStimulus(4'hC);
    checkOutput("cancel exit", {11'h0, exitPulse}, 12'h1);
    checkOutput("cancel credValid", {11'h0, credValid}, 12'h0);
    checkOutput("cancel accNumber", accNumber, 12'h000);
    @(negedge clk);
    checkOutput("exit single cycle", {11'h0, exitPulse}, 12'h0);

    $display("[TB] Entry errors");
    applyStimulus(4'd4);
    applyStimulus(4'd5);
    applyStimulus(4'hB);
    checkOutput("short enter keyError", {11'h0, keyError}, 12'h1);
    applyStimulus(4'd6);
    checkOutput("keyError cleared", {11'h0, keyError}, 12'h0);
    checkOutput("acc 456", accNumber, 12'h456);
    applyStimulus(4'd9);
    checkOutput("4th digit keyError", {11'h0, keyError}, 12'h1);
    checkOutput("4th digit acc kept", accNumber, 12'h456);
    applyStimulus(4'hA);
    checkOutput("clear acc", accNumber, 12'h000);

    $display("[TB] Lockout");
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'hB);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(4'd7);
      applyStimulus(4'hB);
      repeat (3) @(negedge clk);
      checkOutput("fail authFail", {11'h0, authFail}, 12'h1);
      checkOutput("fail attempts", {9'h0, attempts}, 12'(i));
      checkOutput("fail credValid", {11'h0, credValid}, 12'h0);
    end
    checkOutput("locked high", {11'h0, locked}, 12'h1);
    applyStimulus(4'd1);
    checkOutput("locked key ignored", {11'h0, keyError}, 12'h0);
    checkOutput("locked acc kept", accNumber, 12'h123);
    applyStimulus(4'hD);
    checkOutput("locked invalid ignored", {11'h0, keyError}, 12'h0);
    repeat (16) @(negedge clk);
    checkOutput("still locked", {11'h0, locked}, 12'h1);
    repeat (7) @(negedge clk);
    checkOutput("unlocked", {11'h0, locked}, 12'h0);
    checkOutput("unlock attempts", {9'h0, attempts}, 12'h0);
    checkOutput("unlock acc cleared", accNumber, 12'h000);

    $display("[TB] Timeout");
    applyStimulus(4'd1);
    repeat (49) @(negedge clk);
    checkOutput("no exit at 49", {11'h0, exitPulse}, 12'h0);
    @(negedge clk);
    checkOutput("timeout exit", {11'h0, exitPulse}, 12'h1);
    checkOutput("timeout acc", accNumber, 12'h000);
    applyStimulus(4'd2);
    repeat (49) @(negedge clk);
    applyStimulus(4'd3);
    checkOutput("key beats expiry exit", {11'h0, exitPulse}, 12'h0);
    checkOutput("key beats expiry acc", accNumber, 12'h023);
    applyStimulus(4'hC);
    checkOutput("acc cancel exit", {11'h0, exitPulse}, 12'h1);

    $display("[TB] Cancel at sample");
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'hB);
    applyStimulus(4'd7);
    applyStimulus(4'hB);
    repeat (3) @(negedge clk);
    checkOutput("pre fail attempts", {9'h0, attempts}, 12'h1);
    applyStimulus(4'd7);
    applyStimulus(4'hB);
    @(negedge clk);
    applyStimulus(4'hC);
    checkOutput("sample cancel exit", {11'h0, exitPulse}, 12'h1);
    checkOutput("sample cancel authFail", {11'h0, authFail}, 12'h0);
    checkOutput("sample cancel attempts", {9'h0, attempts}, 12'h1);
    checkOutput("sample cancel credValid", {11'h0, credValid}, 12'h0);
    @(negedge clk);
    checkOutput("late authFail", {11'h0, authFail}, 12'h0);

    $display("[TB] Reset during lockout");
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    applyStimulus(4'd3);
    applyStimulus(4'hB);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'd7);
      applyStimulus(4'hB);
      repeat (3) @(negedge clk);
    end
    checkOutput("relock", {11'h0, locked}, 12'h1);
    checkOutput("relock attempts", {9'h0, attempts}, 12'h3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst locked", {11'h0, locked}, 12'h0);
    checkOutput("rst attempts", {9'h0, attempts}, 12'h0);
    checkOutput("rst accNumber", accNumber, 12'h000);
    checkOutput("rst pin", {8'h0, pin}, 12'h0);
    applyStimulus(4'd4);
    checkOutput("post rst entry", accNumber, 12'h004);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Upstream credential-entry stage for the ATM controller. Collects keypad strobes into a 3-digit BCD account number and 1-digit PIN, presents them to the ATM's authentication inputs, and counts failed attempts with a timed lockout. Drives the ATM's `exit` on cancel or inactivity timeout. Consumes the ATM's `isAuthenticated` result.

## Interface
- `MAX_ATTEMPTS`, default 3: consecutive failed authentications before lockout (1..7).
- `LOCKOUT_CYCLES`, default 1000: cycles spent in LOCKED (≥1).
- `TIMEOUT_CYCLES`, default 5000: inactivity limit in cycles (≥2).
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `keyValid` in 1: one-cycle strobe; `keyCode` is valid this cycle.
- `keyCode` in 4: 0–9 digit, 4'hA clear, 4'hB enter, 4'hC cancel, 4'hD–4'hF invalid.
- `isAuthenticated` in 1: ATM authentication result for the presented credentials.
- `accNumber` out 12: BCD account number, most significant digit first, to ATM.
- `pin` out 4: PIN digit, to ATM.
- `credValid` out 1: high while credentials are presented (CHECK and SESSION).
- `exit` out 1: one-cycle pulse ending the ATM session.
- `locked` out 1: high in LOCKED.
- `keyError` out 1: one-cycle pulse on a rejected key.
- `authFail` out 1: one-cycle pulse on each failed check.
- `attempts` out 3: current failed-attempt count.

## Operation
- States: ACC_ENTRY, PIN_ENTRY, CHECK, SESSION, LOCKED. Reset state is ACC_ENTRY.
- ACC_ENTRY, digit with `accCount` < 3: `accNumber <= {accNumber[7:0], keyCode}` and `accCount` increments.
  - A 4th digit is rejected: `keyError` pulses and `accNumber` is unchanged.
  - Clear: `accNumber` = 0 and `accCount` = 0.
  - Enter with `accCount` == 3: go to PIN_ENTRY. Enter with `accCount` < 3: `keyError` pulses and the state is unchanged.
- PIN_ENTRY, first digit: `pin <= keyCode` and `pinSet` = 1.
  - A second digit is rejected with `keyError`.
  - Clear: `pin` = 0 and `pinSet` = 0.
  - Enter with `pinSet`: go to CHECK. Enter without `pinSet`: `keyError` pulses.
- CHECK: `credValid` = 1 for exactly 2 cycles. `isAuthenticated` is sampled on the 2nd cycle.
  - Pass: go to SESSION and set `attempts` = 0.
  - Fail: `authFail` pulses and `attempts` increments. If `attempts` reaches `MAX_ATTEMPTS`, go to LOCKED. Otherwise go to PIN_ENTRY with `pin` and `pinSet` cleared and `accNumber` kept.
  - In CHECK, all keys except cancel are ignored; ignored keys do not pulse `keyError`.
- SESSION: `credValid`, `accNumber` and `pin` are held. Digit, clear and enter keys are ignored.
- Cancel in ACC_ENTRY, PIN_ENTRY, CHECK or SESSION:
  - `exit` pulses.
  - `accNumber`, `pin`, `accCount` and `pinSet` are cleared.
  - State goes to ACC_ENTRY.
  - `attempts` is kept; a cancel during CHECK does not count as an attempt.
- LOCKED: `locked` = 1 and all keys are ignored. A down-counter loads `LOCKOUT_CYCLES` on entry. When it reaches 0: go to ACC_ENTRY, set `attempts` = 0, clear credentials.
- Inactivity timer:
  - Runs in PIN_ENTRY, CHECK and SESSION, and in ACC_ENTRY when `accCount` > 0.
  - Reloads on any `keyValid` and on entry to any state.
  - On expiry after `TIMEOUT_CYCLES` idle cycles, the action is identical to cancel.
  - Frozen at reload value in LOCKED and in empty ACC_ENTRY.
- Invalid codes D–F: `keyError` pulses in ACC_ENTRY and PIN_ENTRY; ignored elsewhere.

## Timing
- All outputs are registered. Reset values: `accNumber` 0, `pin` 0, `credValid` 0, `exit` 0, `locked` 0, `keyError` 0, `authFail` 0, `attempts` 0.
- Key to register update: 1 cycle. `keyError`, `exit` and `authFail` are asserted in the cycle after the causing strobe, expiry or sample.
- Enter in PIN_ENTRY at edge N: `credValid` is high from N+1. `isAuthenticated` is sampled at edge N+2. The SESSION, PIN_ENTRY or LOCKED state and `authFail` are visible after N+3. On fail, `credValid` drops at N+3.
- `rst` overrides every event in the same cycle.
- `keyValid` in the same cycle as timer expiry: the key wins, it is processed and the timer reloads.
- Cancel in the same cycle as the CHECK sample: cancel wins and no attempt is counted.
- `isAuthenticated` is ignored outside CHECK.
- Reset during any state, including LOCKED: immediate return to ACC_ENTRY with all reset values; the lockout is abandoned.

## Test plan
Benches use `TIMEOUT_CYCLES`=50, `LOCKOUT_CYCLES`=20, `MAX_ATTEMPTS`=3.
- Login: keys 1,2,3,enter,7,enter with `isAuthenticated`=1 -> `accNumber`=12'h123, `pin`=7, `credValid` high from 1 cycle after the second enter, SESSION, `attempts`=0.
- Entry errors: keys 4,5,enter -> `keyError` pulse, state stays ACC_ENTRY. Then 6,9 -> `keyError` on the 9, `accNumber`=12'h456. Then clear -> `accNumber`=0.
- Lockout: three PIN checks with `isAuthenticated`=0 -> three `authFail` pulses, `attempts` 1,2,3, `locked`=1. Keys ignored for 20 cycles. Then ACC_ENTRY with `attempts`=0 and `locked`=0.
- Cancel and timeout:
  - Cancel in SESSION -> single-cycle `exit`, `credValid`=0, `accNumber`=0.
  - Separately, key 1 then 50 idle cycles -> `exit` pulse and `accNumber`=0.
  - 49 idle cycles then a key -> no `exit`.
- Corner cases:
  - Cancel coincident with the CHECK sample cycle -> `exit` pulse, no `authFail`, `attempts` unchanged.
  - `rst` asserted mid-LOCKED -> all outputs return to reset values on the next edge.
